// File: rtl/mdu_stall_sequencer.sv
// Stall/bubble sequencer for multi-cycle M-extension ops held in execute.
// Optional stall-cycle counter is built only when MDU_STALL_COUNT_EN is defined.
module mdu_stall_sequencer #(
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mdu_req_e,
  input  logic             is_div_e,
  input  logic             flush_e,
  input  logic             div_done,
  output logic             div_start,
  output logic             div_abort,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             bubble_m,
  output logic             result_valid,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  // The accept cycle is the first stall cycle, so the wait state covers the rest.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 2);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    stall        = 1'b0;
    div_start    = 1'b0;
    div_abort    = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b0;
    if (!start) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          if (mdu_req_e) begin
            if (flush_e) begin
              div_abort = is_div_e;
            end else begin
              stall = 1'b1;
              if (is_div_e) begin
                div_start = 1'b1;
                state_nxt = DIV_WAIT;
              end else begin
                cnt_nxt   = MUL_LOAD;
                state_nxt = MUL_WAIT;
              end
            end
          end
        end
        MUL_WAIT: begin
          if (flush_e) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else if (cnt != 4'd0) begin
            stall   = 1'b1;
            cnt_nxt = cnt - 4'd1;
          end else begin
            result_valid = 1'b1;
            state_nxt    = IDLE;
          end
        end
        DIV_WAIT: begin
          // flush has priority over a coincident div_done
          if (flush_e) begin
            div_abort = 1'b1;
            state_nxt = IDLE;
          end else if (div_done) begin
            result_valid = 1'b1;
            state_nxt    = IDLE;
          end else begin
            stall = 1'b1;
          end
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign stall_f  = stall;
  assign stall_d  = stall;
  assign stall_e  = stall;
  assign bubble_m = stall;

`ifdef MDU_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall_e && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mdu_stall_sequencer.sv
// Scoreboard bench for mdu_stall_sequencer: per-cycle expected outputs are queued
// as stimulus is driven and popped when the outputs settle.
module tb_mdu_stall_sequencer;

  localparam int MUL_LAT = 3;
  localparam int CW      = 4;

  // input rows: {rst, start, mdu_req_e, is_div_e, flush_e, div_done}
  localparam logic [5:0] I_IDLE = 6'b010000;
  localparam logic [5:0] I_MUL  = 6'b011000;
  localparam logic [5:0] I_DIV  = 6'b011100;
  localparam logic [5:0] I_DIVD = 6'b011101;
  localparam logic [5:0] I_DONE = 6'b010001;
  localparam logic [5:0] I_DNM  = 6'b011001;
  localparam logic [5:0] I_FL   = 6'b010010;
  localparam logic [5:0] I_FLD  = 6'b010011;
  localparam logic [5:0] I_RQFD = 6'b011110;
  localparam logic [5:0] I_RQFM = 6'b011010;
  localparam logic [5:0] I_OFF  = 6'b001000;
  localparam logic [5:0] I_OFFD = 6'b000001;
  localparam logic [5:0] I_RST  = 6'b100000;
  localparam logic [5:0] I_RSTR = 6'b111000;

  // output vector: {div_start, div_abort, stall_f, stall_d, stall_e, bubble_m, result_valid, busy}
  localparam logic [7:0] Z    = 8'h00;
  localparam logic [7:0] AMUL = 8'h3C;
  localparam logic [7:0] ADIV = 8'hBC;
  localparam logic [7:0] WT   = 8'h3D;
  localparam logic [7:0] RES  = 8'h03;
  localparam logic [7:0] DABT = 8'h41;
  localparam logic [7:0] ABT  = 8'h01;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, mdu_req_e = 1'b0, is_div_e = 1'b0, flush_e = 1'b0, div_done = 1'b0;
  logic div_start, div_abort, stall_f, stall_d, stall_e, bubble_m, result_valid, busy;
  logic [CW-1:0] stall_cycles;
  wire  [7:0] outs = {div_start, div_abort, stall_f, stall_d, stall_e, bubble_m, result_valid, busy};

  int vecs = 0;
  int errs = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  mdu_stall_sequencer #(.MUL_LATENCY(MUL_LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .mdu_req_e(mdu_req_e), .is_div_e(is_div_e),
    .flush_e(flush_e), .div_done(div_done), .div_start(div_start), .div_abort(div_abort),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .bubble_m(bubble_m),
    .result_valid(result_valid), .busy(busy), .stall_cycles(stall_cycles)
  );

  task automatic drive(input logic [5:0] v);
    @(negedge clk);
    {rst, start, mdu_req_e, is_div_e, flush_e, div_done} = v;
  endtask

  task automatic test_reset();
    logic [13:0] t [$];
    logic [7:0] e;
    drive(I_RST);
    drive(I_RST);
    drive(I_IDLE);
    sb.push_back(Z);
    #1;
    e = sb.pop_front();
    vecs++;
    if (outs !== e) begin errs++; $display("FAIL reset_outs got=%b expected=%b", outs, e); end
    vecs++;
    if (stall_cycles !== '0) begin errs++; $display("FAIL reset_count got=%0d expected=0", stall_cycles); end
    // rst mid-divide: outputs stay live in the rst cycle, zero after, and no div_abort
    t = '{{I_DIV, ADIV}, {I_MUL, WT}, {I_RSTR, WT}, {I_IDLE, Z}, {I_IDLE, Z}};
    foreach (t[i]) begin
      drive(t[i][13:8]);
      sb.push_back(t[i][7:0]);
      #1;
      e = sb.pop_front();
      vecs++;
      if (outs !== e) begin errs++; $display("FAIL reset_mid[%0d] got=%b expected=%b", i, outs, e); end
    end
  endtask

  task automatic test_mul();
    logic [13:0] t [$];
    logic [7:0] e;
    t.push_back({I_IDLE, Z});
    t.push_back({I_MUL, AMUL});
    for (int k = 1; k <= MUL_LAT - 2; k++) t.push_back({I_MUL, WT});
    t.push_back({I_DIV, RES});
    t.push_back({I_IDLE, Z});
    foreach (t[i]) begin
      drive(t[i][13:8]);
      sb.push_back(t[i][7:0]);
      #1;
      e = sb.pop_front();
      vecs++;
      if (outs !== e) begin errs++; $display("FAIL mul[%0d] got=%b expected=%b", i, outs, e); end
    end
  endtask

  task automatic test_div();
    logic [13:0] t [$];
    logic [7:0] e;
    t.push_back({I_IDLE, Z});
    t.push_back({I_DIVD, ADIV});
    for (int k = 0; k < 8; k++) t.push_back({I_MUL, WT});
    t.push_back({I_DONE, RES});
    t.push_back({I_IDLE, Z});
    foreach (t[i]) begin
      drive(t[i][13:8]);
      sb.push_back(t[i][7:0]);
      #1;
      e = sb.pop_front();
      vecs++;
      if (outs !== e) begin errs++; $display("FAIL div[%0d] got=%b expected=%b", i, outs, e); end
    end
  endtask

  task automatic test_flush();
    logic [13:0] t [$];
    logic [7:0] e;
    t = '{{I_DIV, ADIV}, {I_DIV, WT}, {I_DIV, WT}, {I_DIV, WT}, {I_FLD, DABT}, {I_IDLE, Z},
          {I_MUL, AMUL}, {I_FL, ABT}, {I_IDLE, Z}};
    foreach (t[i]) begin
      drive(t[i][13:8]);
      sb.push_back(t[i][7:0]);
      #1;
      e = sb.pop_front();
      vecs++;
      if (outs !== e) begin errs++; $display("FAIL flush[%0d] got=%b expected=%b", i, outs, e); end
    end
  endtask

  task automatic test_flush_idle();
    logic [13:0] t [$];
    logic [7:0] e;
    // div_abort is not examined here: only acceptance must be blocked
    t = '{{I_RQFD, Z}, {I_RQFM, Z}, {I_IDLE, Z}};
    foreach (t[i]) begin
      drive(t[i][13:8]);
      sb.push_back(t[i][7:0]);
      #1;
      e = sb.pop_front();
      vecs++;
      if ((outs & 8'hBF) !== e) begin errs++; $display("FAIL flush_idle[%0d] got=%b expected=%b", i, outs, e); end
    end
  endtask

  task automatic test_start_drop();
    logic [13:0] t [$];
    logic [7:0] e;
    t = '{{I_MUL, AMUL}, {I_OFF, Z}, {I_IDLE, Z}, {I_MUL, AMUL}, {I_MUL, WT}, {I_IDLE, RES},
          {I_DIV, ADIV}, {I_IDLE, WT}, {I_OFFD, Z}, {I_IDLE, Z}};
    foreach (t[i]) begin
      drive(t[i][13:8]);
      sb.push_back(t[i][7:0]);
      #1;
      e = sb.pop_front();
      vecs++;
      if (outs !== e) begin errs++; $display("FAIL start_drop[%0d] got=%b expected=%b", i, outs, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] t [$];
    logic [7:0] e;
    t = '{{I_MUL, AMUL}, {I_MUL, WT}, {I_DIV, RES}, {I_DIV, ADIV}, {I_DIV, WT}, {I_DIV, WT},
          {I_DNM, RES}, {I_MUL, AMUL}, {I_MUL, WT}, {I_MUL, RES}, {I_IDLE, Z}};
    foreach (t[i]) begin
      drive(t[i][13:8]);
      sb.push_back(t[i][7:0]);
      #1;
      e = sb.pop_front();
      vecs++;
      if (outs !== e) begin errs++; $display("FAIL back_to_back[%0d] got=%b expected=%b", i, outs, e); end
    end
  endtask

  task automatic test_stall_count();
    logic [13:0] t [$];
    logic [7:0] e;
    int n = 0;
    int want;
    drive(I_RST);
    t.push_back({I_DIV, ADIV});
    for (int k = 0; k < 19; k++) t.push_back({I_IDLE, WT});
    t.push_back({I_DONE, RES});
    t.push_back({I_IDLE, Z});
    foreach (t[i]) begin
      drive(t[i][13:8]);
      sb.push_back(t[i][7:0]);
      #1;
      e = sb.pop_front();
`ifdef MDU_STALL_COUNT_EN
      want = (n > 15) ? 15 : n;
`else
      want = 0;
`endif
      vecs++;
      if (outs !== e) begin errs++; $display("FAIL count_outs[%0d] got=%b expected=%b", i, outs, e); end
      vecs++;
      if (stall_cycles !== CW'(want)) begin
        errs++; $display("FAIL count[%0d] got=%0d expected=%0d", i, stall_cycles, want);
      end
      if (e[3]) n++;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_flush_idle();
    test_start_drop();
    test_back_to_back();
    test_stall_count();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mdu_stall_sequencer.md
# mdu_stall_sequencer

Sequences multi-cycle M-extension operations held in the execute stage. Holds F/D/E and bubbles M for a fixed-latency multiplier or a handshaked iterative divider, then releases the pipeline with a one-cycle result strobe. Its stall/bubble outputs are OR-combined with the hazard unit's stall_f/stall_d/flush_m at the top level. It consumes the hazard unit's flush_e as an abort.

## Interface
Parameters:
- MUL_LATENCY, default 3: total E-stage occupancy of a multiply in cycles; legal range 2..16.
- CNT_W, default 32: width of the optional stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock; the block has one clock.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  global run enable; low forces all outputs to 0 and the FSM to IDLE at the next edge.
- mdu_req_e  input  1  instruction in E is MUL*/DIV*/REM*.
- is_div_e  input  1  qualifies mdu_req_e: 1 = div/rem, 0 = mul.
- flush_e  input  1  hazard unit E-stage flush; aborts any operation.
- div_done  input  1  divider completion pulse.
- div_start  output  1  one-cycle divider launch pulse.
- div_abort  output  1  one-cycle divider kill pulse.
- stall_f, stall_d, stall_e  output  1 each  hold fetch, decode, execute.
- bubble_m  output  1  insert a bubble into M; always equal to stall_e.
- result_valid  output  1  MDU result is valid on E outputs this cycle.
- busy  output  1  FSM not in IDLE.
- stall_cycles  output  CNT_W  saturating stall counter (see Configuration).

## Operation
- States: IDLE, MUL_WAIT, DIV_WAIT. A down-counter cnt is 4 bits wide.
- IDLE, with mdu_req_e=1, flush_e=0 and start=1 (accept cycle T):
  - Assert stall_f/d/e and bubble_m combinationally in T.
  - For a multiply, load cnt = MUL_LATENCY-2 and go to MUL_WAIT.
  - For a divide, pulse div_start in T and go to DIV_WAIT.
- MUL_WAIT:
  - While cnt != 0: assert stalls and decrement cnt.
  - When cnt == 0: deassert stalls, assert result_valid, go to IDLE.
- DIV_WAIT:
  - While div_done=0: assert stalls.
  - When div_done=1: deassert stalls, assert result_valid, go to IDLE.
  - A div_done seen in the accept cycle T is ignored.
- Abort: flush_e=1 in MUL_WAIT or DIV_WAIT, or in the accept cycle.
  - Stalls and result_valid are 0 that cycle, and the FSM goes to IDLE.
  - div_abort pulses if the state is DIV_WAIT, or if the accept cycle was a divide.
  - In IDLE, flush_e=1 blocks acceptance and no div_start is issued.
- Simultaneous flush_e and div_done: the flush wins. result_valid=0 and div_abort=1.
- mdu_req_e and is_div_e are sampled only in IDLE. They are ignored in the wait states.

## Timing
- Reset values: state=IDLE, cnt=0, stall_cycles=0. Every output is 0 in the cycle after rst.
- Multiply: stalls are asserted for exactly MUL_LATENCY-1 cycles (T..T+MUL_LATENCY-2). result_valid is asserted at T+MUL_LATENCY-1.
- Divide: stalls are asserted from T through the cycle before div_done. result_valid is asserted in the div_done cycle.
- Back-to-back MDU ops:
  - The next op is accepted no earlier than the cycle after a result_valid.
  - There is no dead cycle beyond the normal E advance.
- rst or start=0 mid-operation: outputs drop to 0 immediately (start) or at the next edge (rst). No div_abort is issued; the divider is reset by the same rst.
- All outputs except stall_cycles are Mealy functions of the state and the inputs.

## Configuration
- Macro MDU_STALL_COUNT_EN.
  - Defined: stall_cycles increments by 1 every cycle stall_e=1 and saturates at all-ones. It is cleared only by rst.
  - Undefined: stall_cycles is tied to 0 and no counter register is built. The port remains.

## Test plan
- MUL_LATENCY=3, single mul at T=10:
  - stall_e=1 at cycles 10 and 11.
  - result_valid=1 only at cycle 12; busy=1 at cycles 11 and 12.
- Div accepted at T=20, div_done at 29:
  - div_start=1 only at cycle 20, and stalls are asserted on cycles 20–28.
  - result_valid=1 at cycle 29, and the state is IDLE at cycle 30.
- Div in flight, flush_e and div_done both at cycle 25: div_abort=1, result_valid=0, stalls=0, IDLE at cycle 26.
- mdu_req_e=1 and flush_e=1 in IDLE: no div_start, no stall, busy stays 0.
- start deasserted at cycle 15 during a mul:
  - All outputs are 0 at cycle 15 and the state is IDLE at cycle 16.
  - With start=1 again, a new mul is accepted normally.
- MDU_STALL_COUNT_EN with CNT_W=4 and 20 stall cycles: stall_cycles holds at 15. Without the macro it reads 0.
